// File: rtl/sb_cfg_pkg.sv
// sb_cfg_pkg
// Shared constants, types and the selector legality rule for the switch-box
// configuration loader.
//   - geometry of the 6x6 switch box (wires per side, selector width)
//   - side codes carried in selector bits [2:0]
//   - frame layout: entry bases, bus width, sync byte
//   - loader state enum and error codes
//   - selector_legal(): legality of one selector for a given entry slot
package sb_cfg_pkg;

  localparam int N_TB  = 5;
  localparam int N_LR  = 4;
  localparam int SEL_W = 6;
  localparam int N_ENT = 2 * N_TB + 2 * N_LR;
  localparam int BUS_W = SEL_W * N_ENT;

  localparam logic [7:0] SYNC = 8'hA5;

  // Entry k occupies cfg_bus[6k+5:6k]
  localparam int TOP_BASE   = 0;
  localparam int BOT_BASE   = 5;
  localparam int LEFT_BASE  = 10;
  localparam int RIGHT_BASE = 14;

  localparam logic [2:0] SIDE_OFF   = 3'd0;
  localparam logic [2:0] SIDE_TOP   = 3'd1;
  localparam logic [2:0] SIDE_RIGHT = 3'd2;
  localparam logic [2:0] SIDE_BOT   = 3'd3;
  localparam logic [2:0] SIDE_LEFT  = 3'd4;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LOAD,
    ST_CHK,
    ST_COMMIT
  } state_t;

  // sel = {source index[2:0], source side[2:0]}. Illegal when the side code is
  // undefined, the index is beyond that side's wire count, or the selector
  // names the very wire that this entry drives.
  function automatic logic selector_legal(input logic [4:0] entry_idx,
                                          input logic [SEL_W-1:0] sel);
    logic [2:0] side;
    logic [2:0] idx;
    logic [2:0] own_side;
    logic [2:0] own_idx;
    logic       legal;

    side = sel[2:0];
    idx  = sel[5:3];

    if (int'(entry_idx) < BOT_BASE) begin
      own_side = SIDE_TOP;
      own_idx  = 3'(int'(entry_idx) - TOP_BASE);
    end else if (int'(entry_idx) < LEFT_BASE) begin
      own_side = SIDE_BOT;
      own_idx  = 3'(int'(entry_idx) - BOT_BASE);
    end else if (int'(entry_idx) < RIGHT_BASE) begin
      own_side = SIDE_LEFT;
      own_idx  = 3'(int'(entry_idx) - LEFT_BASE);
    end else begin
      own_side = SIDE_RIGHT;
      own_idx  = 3'(int'(entry_idx) - RIGHT_BASE);
    end

    case (side)
      SIDE_OFF:             legal = 1'b1;
      SIDE_TOP, SIDE_BOT:   legal = (int'(idx) < N_TB);
      SIDE_RIGHT, SIDE_LEFT: legal = (int'(idx) < N_LR);
      default:              legal = 1'b0;
    endcase

    if (side != SIDE_OFF && side == own_side && idx == own_idx) legal = 1'b0;

    return legal;
  endfunction

endpackage

// File: rtl/sb_cfg_loader_if.sv
// sb_cfg_loader_if
// Serial configuration stream between the chip-level bitstream shifter
// (master) and the switch-box loader (slave).
//   cfg_din    master->slave  serial config bit
//   cfg_valid  master->slave  cfg_din valid this cycle
//   cfg_abort  master->slave  abort an in-progress load
//   cfg_ready  slave->master  loader accepts a bit this cycle
interface sb_cfg_loader_if;

  logic cfg_din;
  logic cfg_valid;
  logic cfg_ready;
  logic cfg_abort;

  modport master (
    output cfg_din,
    output cfg_valid,
    output cfg_abort,
    input  cfg_ready
  );

  modport slave (
    input  cfg_din,
    input  cfg_valid,
    input  cfg_abort,
    output cfg_ready
  );

endinterface

// File: rtl/sb_sel_check.sv
// sb_sel_check
// Combinational legality of one completed selector entry.
//   entry_idx  in   slot number 0..17 of the entry being completed
//   sel        in   the completed 6-bit selector
//   legal      out  1 when the selector may be committed in that slot
module sb_sel_check
  import sb_cfg_pkg::*;
(
  input  logic [4:0]       entry_idx,
  input  logic [SEL_W-1:0] sel,
  output logic             legal
);

  assign legal = selector_legal(entry_idx, sel);

endmodule

// File: rtl/sb_cfg_loader.sv
// sb_cfg_loader
// Serial configuration loader for one 6x6 switch box. Hunts for the sync
// byte, shifts 18 selectors plus a 6-bit XOR checksum into a shadow register,
// and commits the whole set atomically when every entry is legal and the
// checksum matches.
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   cfg_if      slave modport: cfg_din/cfg_valid/cfg_abort in, cfg_ready out
//   cfg_bus     out  committed selectors, entry k at [6k+5:6k]
//   cfg_done    out  one-cycle pulse on a successful commit
//   cfg_loaded  out  sticky, set by the first successful commit
//   cfg_err     out  one-cycle pulse on a rejected or aborted frame
//   err_code    out  0 none, 1 checksum, 2 illegal selector, 3 aborted
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_HUNT   | shift incoming bits, look for the sync byte
// ST_LOAD   | capture 108 selector bits, check each entry as it completes
// ST_CHK    | capture the 6 checksum bits
// ST_COMMIT | one cycle, not ready; commit or reject the frame
module sb_cfg_loader
  import sb_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sb_cfg_loader_if.slave   cfg_if,
  output logic [BUS_W-1:0] cfg_bus,
  output logic             cfg_done,
  output logic             cfg_loaded,
  output logic             cfg_err,
  output logic [1:0]       err_code
);

  state_t           state;
  logic [7:0]       sync_sr;
  logic [6:0]       bit_cnt;   // bits left in LOAD, terminal count at 0
  logic [2:0]       ent_bit;   // bits left in the current entry / checksum
  logic [4:0]       ent_idx;
  logic [SEL_W-1:0] ent_acc;
  logic [BUS_W-1:0] shadow;
  logic [SEL_W-1:0] xor_acc;
  logic [SEL_W-1:0] csum_rx;
  logic             illegal;
  logic             ready_q;

  logic             xfer;
  logic [7:0]       sync_next;
  logic [SEL_W-1:0] ent_next;
  logic             ent_legal;

  assign cfg_if.cfg_ready = ready_q;

  assign xfer      = cfg_if.cfg_valid & ready_q;
  assign sync_next = {sync_sr[6:0], cfg_if.cfg_din};
  assign ent_next  = {ent_acc[SEL_W-2:0], cfg_if.cfg_din};

  // Checks the entry that completes with this bit, so legality is known
  // without a wide compare at commit time.
  sb_sel_check u_sel_check (
    .entry_idx (ent_idx),
    .sel       (ent_next),
    .legal     (ent_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HUNT;
      sync_sr    <= 8'd0;
      bit_cnt    <= 7'd0;
      ent_bit    <= 3'd0;
      ent_idx    <= 5'd0;
      ent_acc    <= '0;
      shadow     <= '0;
      xor_acc    <= '0;
      csum_rx    <= '0;
      illegal    <= 1'b0;
      ready_q    <= 1'b1;
      cfg_bus    <= '0;
      cfg_done   <= 1'b0;
      cfg_loaded <= 1'b0;
      cfg_err    <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;

      if ((state == ST_LOAD || state == ST_CHK) && cfg_if.cfg_abort) begin
        state    <= ST_HUNT;
        shadow   <= '0;
        sync_sr  <= 8'd0;
        cfg_err  <= 1'b1;
        err_code <= ERR_ABORT;
      end else begin
        case (state)
          ST_HUNT: begin
            if (xfer) begin
              if (sync_next == SYNC) begin
                state   <= ST_LOAD;
                sync_sr <= 8'd0;
                bit_cnt <= 7'(BUS_W - 1);
                ent_bit <= 3'(SEL_W - 1);
                ent_idx <= 5'd0;
                xor_acc <= '0;
                illegal <= 1'b0;
              end else begin
                sync_sr <= sync_next;
              end
            end
          end

          ST_LOAD: begin
            if (xfer) begin
              ent_acc <= ent_next;
              if (ent_bit == 3'd0) begin
                // First entry ends up in the low slice after 17 more shifts.
                shadow  <= {ent_next, shadow[BUS_W-1:SEL_W]};
                xor_acc <= xor_acc ^ ent_next;
                if (!ent_legal) illegal <= 1'b1;
                ent_idx <= ent_idx + 5'd1;
                ent_bit <= 3'(SEL_W - 1);
              end else begin
                ent_bit <= ent_bit - 3'd1;
              end
              if (bit_cnt == 7'd0) begin
                state <= ST_CHK;
              end else begin
                bit_cnt <= bit_cnt - 7'd1;
              end
            end
          end

          ST_CHK: begin
            if (xfer) begin
              csum_rx <= {csum_rx[SEL_W-2:0], cfg_if.cfg_din};
              if (ent_bit == 3'd0) begin
                state   <= ST_COMMIT;
                ready_q <= 1'b0;
              end else begin
                ent_bit <= ent_bit - 3'd1;
              end
            end
          end

          ST_COMMIT: begin
            state   <= ST_HUNT;
            ready_q <= 1'b1;
            if (csum_rx != xor_acc) begin
              cfg_err  <= 1'b1;
              err_code <= ERR_CSUM;
            end else if (illegal) begin
              cfg_err  <= 1'b1;
              err_code <= ERR_ILLEGAL;
            end else begin
              cfg_bus    <= shadow;
              cfg_done   <= 1'b1;
              cfg_loaded <= 1'b1;
              err_code   <= ERR_NONE;
            end
          end

          default: begin
            state   <= ST_HUNT;
            ready_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
